// File: rtl/core_dma_pkg.sv
// Shared definitions for the CPU core and the sprite DMA engine:
// bus cycle timing, DMA state encoding and bus request layout.
package core_dma_pkg;

  // Master clocks per CPU cycle; the core divider uses the same value.
  localparam int unsigned C_TICKS     = 12;
  localparam logic [15:0] C_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] C_DEST_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // One bus cycle as driven towards the system bus.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        rdwr;
  } bus_req_t;

  // A core write to the trigger register starts a transfer.
  function automatic logic f_is_trigger(input logic [15:0] addr,
                                        input logic        rdwr,
                                        input logic [15:0] trig);
    return (!rdwr) && (addr == trig);
  endfunction

endpackage

// File: rtl/dma_timing.sv
// CPU-cycle timing: free-running tick counter, commit strobe (tick==0)
// and a parity bit that toggles on every commit edge.
module dma_timing #(
  parameter int P_TICKS = 12
) (
  input  logic I_clock,
  input  logic I_reset,
  output logic o_commit,
  output logic o_parity
);

  localparam int W = (P_TICKS > 1) ? $clog2(P_TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(P_TICKS - 1);

  logic [W-1:0] r_tick;
  logic         r_parity;

  assign o_commit = (r_tick == '0);
  assign o_parity = r_parity;

  // Tick wraps at P_TICKS-1; parity flips once per CPU cycle.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_tick   <= '0;
      r_parity <= 1'b0;
    end else begin
      r_tick <= (r_tick == LAST) ? '0 : r_tick + 1'b1;
      if (o_commit) r_parity <= ~r_parity;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA engine: passes core bus cycles through, snoops writes to the
// trigger register, then halts the core and copies one 256-byte page to
// the OAM data port as alternating read/write CPU cycles.
module oam_dma
  import core_dma_pkg::*;
#(
  parameter int          P_TICKS     = C_TICKS,
  parameter logic [15:0] P_TRIG_ADDR = C_TRIG_ADDR,
  parameter logic [15:0] P_DEST_ADDR = C_DEST_ADDR
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_ready,
  output logic        O_active
);

  logic       w_commit;
  logic       w_parity;
  dma_state_t r_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_latch;
  logic       r_ready;
  logic       r_active;
  bus_req_t   w_bus;

  dma_timing #(.P_TICKS(P_TICKS)) u_timing (
    .I_clock (I_clock),
    .I_reset (I_reset),
    .o_commit(w_commit),
    .o_parity(w_parity)
  );

  // Transfer sequencing; every transition lands on a commit edge so the
  // core is frozen and released at the same tick phase.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_state  <= IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_latch  <= 8'h00;
      r_ready  <= 1'b1;
      r_active <= 1'b0;
    end else if (w_commit) begin
      case (r_state)
        IDLE: begin
          if (f_is_trigger(I_cpu_addr, I_cpu_rdwr, P_TRIG_ADDR)) begin
            r_page  <= I_cpu_wr_data;
            r_ready <= 1'b0;
            r_state <= HALT;
          end
        end
        HALT: begin
          // Reads must start on an even cycle; burn one more if odd.
          if (w_parity) begin
            r_state <= ALIGN;
          end else begin
            r_idx    <= 8'h00;
            r_active <= 1'b1;
            r_state  <= READ;
          end
        end
        ALIGN: begin
          r_idx    <= 8'h00;
          r_active <= 1'b1;
          r_state  <= READ;
        end
        READ: begin
          r_latch <= I_rd_data;
          r_state <= WRITE;
        end
        WRITE: begin
          r_idx <= r_idx + 8'd1;
          if (r_idx == 8'hFF) begin
            r_ready  <= 1'b1;
            r_active <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_state <= READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus ownership: the core drives the bus except in READ/WRITE.
  always_comb begin
    w_bus = '{addr: I_cpu_addr, wr_data: I_cpu_wr_data, rdwr: I_cpu_rdwr};
    if (r_state == READ) begin
      w_bus.addr = {r_page, r_idx};
      w_bus.rdwr = 1'b1;
    end else if (r_state == WRITE) begin
      w_bus.addr    = P_DEST_ADDR;
      w_bus.wr_data = r_latch;
      w_bus.rdwr    = 1'b0;
    end
  end

  assign O_addr    = w_bus.addr;
  assign O_wr_data = w_bus.wr_data;
  assign O_rdwr    = w_bus.rdwr;
  assign O_ready   = r_ready;
  assign O_active  = r_active;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: acts as CPU core and memory, stepping one CPU cycle
// (12 master clocks) at a time and comparing bus outputs per cycle with a
// cycle-level model of the transfer.
module tb_oam_dma;

  localparam int          TICKS = 12;
  localparam logic [15:0] TRIG  = 16'h4014;
  localparam logic [15:0] DEST  = 16'h2004;

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b0;
  logic [15:0] I_cpu_addr = 16'h0000;
  logic [7:0]  I_cpu_wr_data = 8'h00;
  logic        I_cpu_rdwr = 1'b1;
  logic [7:0]  I_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic        O_ready;
  logic        O_active;

  logic [7:0] mem [0:65535];
  int n_chk = 0;
  int n_fail = 0;
  int k = 0;  // index of the commit edge that ends the current cycle

  assign I_rd_data = mem[O_addr];

  oam_dma dut (
    .I_clock      (I_clock),
    .I_reset      (I_reset),
    .I_cpu_addr   (I_cpu_addr),
    .I_cpu_wr_data(I_cpu_wr_data),
    .I_cpu_rdwr   (I_cpu_rdwr),
    .I_rd_data    (I_rd_data),
    .O_addr       (O_addr),
    .O_wr_data    (O_wr_data),
    .O_rdwr       (O_rdwr),
    .O_ready      (O_ready),
    .O_active     (O_active)
  );

  always #5 I_clock = ~I_clock;

  // Called at a negedge: present a core cycle, let outputs settle.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    I_cpu_addr    = a;
    I_cpu_wr_data = d;
    I_cpu_rdwr    = rw;
    #1;
  endtask

  // Finish the CPU cycle: its last master clock is the commit edge.
  task automatic step();
    repeat (TICKS) @(posedge I_clock);
    @(negedge I_clock);
    k++;
  endtask

  // Release reset at a negedge; the next posedge is commit edge 0.
  task automatic release_reset();
    drive(16'h0000, 8'h00, 1'b1);
    I_reset = 1'b1;
    @(posedge I_clock);
    @(negedge I_clock);
    k = 1;
  endtask

  task automatic test_reset();
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    I_reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge I_clock);
      a = 16'($urandom); d = 8'($urandom); rw = 1'($urandom);
      drive(a, d, rw);
      n_chk++;
      if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== a ||
          O_rdwr !== rw || O_wr_data !== d) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b act=%b addr=%h rw=%b wd=%h want rdy=1 act=0 addr=%h rw=%b wd=%h",
                 O_ready, O_active, O_addr, O_rdwr, O_wr_data, a, rw, d);
      end
    end
    @(negedge I_clock);
    release_reset();
  endtask

  task automatic test_passthrough();
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom_range(0, 16'h07FF)); d = 8'($urandom); rw = 1'($urandom);
      drive(a, d, rw);
      n_chk++;
      if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== a ||
          O_rdwr !== rw || O_wr_data !== d) begin
        n_fail++;
        $display("FAIL passthrough[%0d]: got rdy=%b act=%b addr=%h rw=%b wd=%h want rdy=1 act=0 addr=%h rw=%b wd=%h",
                 n, O_ready, O_active, O_addr, O_rdwr, O_wr_data, a, rw, d);
      end
      step();
    end
  endtask

  task automatic test_non_trigger();
    logic [15:0] addrs [3];
    logic        rws   [3];
    addrs[0] = 16'h4015; rws[0] = 1'b0;
    addrs[1] = 16'h2014; rws[1] = 1'b0;
    addrs[2] = 16'h4014; rws[2] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(addrs[n], 8'($urandom), rws[n]);
      step();
      for (int c = 0; c < 2; c++) begin
        drive(16'h0300, 8'h00, 1'b1);
        n_chk++;
        if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== 16'h0300) begin
          n_fail++;
          $display("FAIL non_trigger[%0d]: addr %h rw %b gave rdy=%b act=%b addr=%h want rdy=1 act=0 addr=0300",
                   n, addrs[n], rws[n], O_ready, O_active, O_addr);
        end
        step();
      end
    end
  endtask

  // Trigger a transfer from `page` and check every CPU cycle until the
  // core is released. halt_par is the parity seen at the HALT commit.
  // With spoof set, the frozen core shows a trigger write throughout.
  task automatic dma_scenario(input logic [7:0] page, input int halt_par, input bit spoof);
    int par, h, nlow, j, i;
    logic [15:0] ca, ea;
    logic [7:0]  cd, ewd;
    logic        crw, erw, erdy, eact, chk_wd;
    if (((k + 1) % 2) != halt_par) begin
      drive(16'h0100, 8'h00, 1'b1);
      step();
    end
    par = (k + 1) % 2;
    h   = 513 + par;
    drive(TRIG, page, 1'b0);
    n_chk++;
    if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== TRIG ||
        O_rdwr !== 1'b0 || O_wr_data !== page) begin
      n_fail++;
      $display("FAIL trigger_write pg=%h: got rdy=%b act=%b addr=%h rw=%b wd=%h want rdy=1 act=0 addr=%h rw=0 wd=%h",
               page, O_ready, O_active, O_addr, O_rdwr, O_wr_data, TRIG, page);
    end
    step();
    nlow = 0;
    for (int w = 1; w <= h + 1; w++) begin
      cd = 8'($urandom);
      if (spoof && w <= h) begin ca = TRIG; crw = 1'b0; end
      else begin ca = 16'h0123; crw = 1'b1; end
      drive(ca, cd, crw);
      erdy = (w > h); eact = 1'b0; ea = ca; erw = crw; ewd = cd; chk_wd = 1'b1;
      if (w <= h && w >= 2 + par) begin
        j = w - 2 - par;
        i = j / 2;
        eact = 1'b1;
        if (j % 2 == 0) begin
          ea = {page, 8'(i)}; erw = 1'b1; chk_wd = 1'b0;
        end else begin
          ea = DEST; erw = 1'b0; ewd = mem[{page, 8'(i)}];
        end
      end
      n_chk++;
      if (O_ready !== erdy || O_active !== eact || O_addr !== ea ||
          O_rdwr !== erw || (chk_wd && O_wr_data !== ewd)) begin
        n_fail++;
        $display("FAIL dma_cycle pg=%h w=%0d: got rdy=%b act=%b addr=%h rw=%b wd=%h want rdy=%b act=%b addr=%h rw=%b wd=%h",
                 page, w, O_ready, O_active, O_addr, O_rdwr, O_wr_data, erdy, eact, ea, erw, ewd);
      end
      if (O_ready === 1'b0) nlow++;
      step();
    end
    n_chk++;
    if (nlow != h) begin
      n_fail++;
      $display("FAIL halt_length pg=%h: got %0d cycles want %0d", page, nlow, h);
    end
  endtask

  task automatic test_even_parity();
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    dma_scenario(8'h02, 0, 1'b0);
  endtask

  task automatic test_odd_parity();
    dma_scenario(8'h02, 1, 1'b0);
  endtask

  task automatic test_page_wrap();
    dma_scenario(8'hFF, int'($urandom_range(0, 1)), 1'b1);
    n_chk++;
    if (dut.r_idx !== 8'h00) begin
      n_fail++;
      $display("FAIL page_wrap_idx: got %h want 00", dut.r_idx);
    end
  endtask

  task automatic test_reset_mid();
    int par, wt;
    logic [7:0] page;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    page = 8'($urandom_range(3, 7));
    drive(TRIG, page, 1'b0);
    par = (k + 1) % 2;
    step();
    // Cycle carrying the write of idx 0x40.
    wt = 2 + par + 2 * 8'h40 + 1;
    for (int w = 1; w < wt; w++) begin
      drive(16'h0123, 8'h00, 1'b1);
      step();
    end
    drive(16'h0456, 8'h77, 1'b1);
    n_chk++;
    if (O_active !== 1'b1 || O_addr !== DEST || O_rdwr !== 1'b0 ||
        O_wr_data !== mem[{page, 8'h40}]) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got act=%b addr=%h rw=%b wd=%h want act=1 addr=%h rw=0 wd=%h",
               O_active, O_addr, O_rdwr, O_wr_data, DEST, mem[{page, 8'h40}]);
    end
    I_reset = 1'b0;
    #1;
    n_chk++;
    if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== 16'h0456 || O_rdwr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_async: got rdy=%b act=%b addr=%h rw=%b want rdy=1 act=0 addr=0456 rw=1",
               O_ready, O_active, O_addr, O_rdwr);
    end
    repeat (3) @(negedge I_clock);
    release_reset();
    for (int n = 0; n < 20; n++) begin
      a = 16'($urandom_range(0, 16'h07FF)); d = 8'($urandom); rw = 1'b1;
      drive(a, d, rw);
      n_chk++;
      if (O_ready !== 1'b1 || O_active !== 1'b0 || O_addr !== a ||
          O_rdwr !== rw || O_wr_data !== d) begin
        n_fail++;
        $display("FAIL reset_mid_after[%0d]: got rdy=%b act=%b addr=%h rw=%b wd=%h want rdy=1 act=0 addr=%h rw=1 wd=%h",
                 n, O_ready, O_active, O_addr, O_rdwr, O_wr_data, a, d);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_passthrough();
    test_non_trigger();
    test_even_parity();
    test_odd_parity();
    test_page_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
